// File: rtl/spi_frame_receiver.sv
// spi_frame_receiver
//   Front end for the SPI register interface. It synchronises the raw
//   SCLK/COPI/nCS pad inputs into the clk domain and deserialises 16-bit
//   mode-0 frames (R/W bit, address, data; MSB first). It validates each
//   frame and emits either a one-cycle register-write strobe or a one-cycle
//   frame-error strobe. Read frames are dropped silently.
//
// Ports
//   clk       in   system clock, all state on rising edge
//   rst       in   asynchronous, active-high reset
//   sclk_in   in   raw SPI clock (asynchronous to clk), mode 0
//   copi_in   in   raw SPI data in, MSB first
//   ncs_in    in   raw SPI chip select, active low
//   wr_valid  out  one-cycle pulse: a validated write is available
//   wr_addr   out  write address, held until the next valid write
//   wr_data   out  write data, held until the next valid write
//   frame_err out  one-cycle pulse: frame rejected
//   busy      out  high while a frame is being shifted in
module spi_frame_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16,
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_ADDR    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk_in,
  input  logic                  copi_in,
  input  logic                  ncs_in,
  output logic                  wr_valid,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  // One past a full frame; the counter parks here so any overrun stays visible.
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
  logic [SYNC_STAGES-1:0] ncs_sync_q,  ncs_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   ncs_prev_q,  ncs_prev_d;

  state_t                 state_q, state_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   wr_valid_q, wr_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;

  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_rise, ncs_rise, ncs_fall;
  logic                   frame_rw;
  logic [ADDR_WIDTH-1:0]  frame_addr;
  logic [DATA_WIDTH-1:0]  frame_data;

  // Synchroniser chains shift toward the MSB; the extra prev flops compare
  // against the chain outputs to give single-cycle edge strobes.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
    copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi_in};
    ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0],  ncs_in};
    sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
    ncs_prev_d  = ncs_sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      copi_sync_q <= copi_sync_d;
      ncs_sync_q  <= ncs_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ncs_prev_q  <= ncs_prev_d;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;
  assign ncs_fall  = ~ncs_s & ncs_prev_q;

  assign frame_rw   = shift_q[FRAME_BITS-1];
  assign frame_addr = shift_q[FRAME_BITS-2 -: ADDR_WIDTH];
  assign frame_data = shift_q[DATA_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      count_q     <= '0;
      wr_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      wr_valid_q  <= wr_valid_d;
      frame_err_q <= frame_err_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // A chip-select edge always wins over a coincident SCLK edge: the frame
  // either opens with an empty count or closes without taking the bit.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    count_d     = count_q;
    wr_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    case (state_q)
      IDLE: begin
        if (ncs_fall) begin
          state_d = SHIFT;
          shift_d = '0;
          count_d = '0;
        end
      end
      SHIFT: begin
        if (ncs_rise) begin
          state_d = CHECK;
        end else if (sclk_rise && !ncs_s) begin
          shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
          if (count_q != CNT_SAT) begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (count_q != CNT_FULL) begin
          frame_err_d = 1'b1;
        end else if (frame_rw) begin
          if (frame_addr > ADDR_WIDTH'(MAX_ADDR)) begin
            frame_err_d = 1'b1;
          end else begin
            wr_valid_d = 1'b1;
            wr_addr_d  = frame_addr;
            wr_data_d  = frame_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_valid  = wr_valid_q;
  assign frame_err = frame_err_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_frame_receiver.sv
// tb_spi_frame_receiver
//   Self-checking bench for spi_frame_receiver. Frames are driven bit by bit
//   on the raw pads; the expected strobe for each frame is queued when the
//   frame starts and popped by a monitor when the DUT pulses.
module tb_spi_frame_receiver;

  localparam int SYNC_STAGES = 2;

  logic       clk;
  logic       rst;
  logic       sclk_in;
  logic       copi_in;
  logic       ncs_in;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       is_err;
    logic [6:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];

  // kind: 0 = silently dropped, 1 = write, 2 = frame error
  typedef struct {
    logic [31:0] bits;
    int          nbits;
    int          gap;
    int          kind;
    logic [6:0]  addr;
    logic [7:0]  data;
  } vec_t;

  vec_t vecs[10];

  logic [6:0] model_addr;
  logic [7:0] model_data;

  spi_frame_receiver #(
    .SYNC_STAGES(SYNC_STAGES),
    .FRAME_BITS (16),
    .ADDR_WIDTH (7),
    .DATA_WIDTH (8),
    .MAX_ADDR   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk_in  (sclk_in),
    .copi_in  (copi_in),
    .ncs_in   (ncs_in),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .frame_err(frame_err),
    .busy     (busy)
  );

  // 10 ns system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic pushExpect(input int kind, input logic [6:0] addr, input logic [7:0] data);
    exp_t e;
    e.is_err = (kind == 2);
    e.addr   = addr;
    e.data   = data;
    if (kind != 0) exp_q.push_back(e);
  endtask

  // Mode 0: COPI changes with SCLK low, sampled on the rise; 4 clk per phase.
  task automatic shiftBits(input logic [31:0] bits, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      sclk_in = 1'b0;
      copi_in = bits[i];
      repeat (4) @(posedge clk);
      #1 sclk_in = 1'b1;
      repeat (4) @(posedge clk);
      #1;
    end
    sclk_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] bits, input int nbits, input int gap);
    @(posedge clk);
    #1 ncs_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    shiftBits(bits, nbits);
    ncs_in = 1'b1;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_valid && frame_err) begin
        checks++;
        errors++;
        $display("[TB] FAIL both_strobes actual=1 required=0");
      end
      if (wr_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pulse actual=wr%0b/err%0b required=none",
                   wr_valid, frame_err);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("pulse_kind_err", 32'(frame_err), 32'(e.is_err));
          if (!e.is_err) begin
            checkOutput("pulse_addr", 32'(wr_addr), 32'(e.addr));
            checkOutput("pulse_data", 32'(wr_data), 32'(e.data));
          end
        end
      end
    end
  end

  initial begin
    int edge_n;

    vecs[0] = '{32'h80A5,   16, 8, 1, 7'h00, 8'hA5};
    vecs[1] = '{32'h0312,   16, 8, 0, 7'h00, 8'h00};
    vecs[2] = '{32'h8533,   16, 8, 2, 7'h00, 8'h00};
    vecs[3] = '{32'h4000,   15, 8, 2, 7'h00, 8'h00};
    vecs[4] = '{32'h10101,  17, 8, 2, 7'h00, 8'h00};
    vecs[5] = '{32'h8101,   16, 3, 1, 7'h01, 8'h01};
    vecs[6] = '{32'h8202,   16, 8, 1, 7'h02, 8'h02};
    vecs[7] = '{32'hFF00,   16, 8, 2, 7'h00, 8'h00};
    vecs[8] = '{32'h847F,   16, 8, 1, 7'h04, 8'h7F};
    vecs[9] = '{32'h83C3,   16, 8, 1, 7'h03, 8'hC3};

    rst     = 1'b1;
    sclk_in = 1'b0;
    copi_in = 1'b0;
    ncs_in  = 1'b1;
    model_addr = '0;
    model_data = '0;

    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_wr_valid",  32'(wr_valid),  0);
    checkOutput("reset_frame_err", 32'(frame_err), 0);
    checkOutput("reset_busy",      32'(busy),      0);
    checkOutput("reset_wr_addr",   32'(wr_addr),   0);
    checkOutput("reset_wr_data",   32'(wr_data),   0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    for (int v = 0; v < 10; v++) begin
      pushExpect(vecs[v].kind, vecs[v].addr, vecs[v].data);
      applyStimulus(vecs[v].bits, vecs[v].nbits, vecs[v].gap);
      if (vecs[v].kind == 1) begin
        model_addr = vecs[v].addr;
        model_data = vecs[v].data;
      end
      if (vecs[v].gap >= 8) begin
        checkOutput($sformatf("hold_addr_v%0d", v), 32'(wr_addr), 32'(model_addr));
        checkOutput($sformatf("hold_data_v%0d", v), 32'(wr_data), 32'(model_data));
        checkOutput($sformatf("idle_busy_v%0d", v), 32'(busy), 0);
      end
    end

    // Reset mid-frame: partial 0x8111 dropped, then a clean frame is accepted.
    @(posedge clk);
    #1 ncs_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    shiftBits(32'h81, 8);
    rst     = 1'b1;
    ncs_in  = 1'b1;
    sclk_in = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("midrst_busy",    32'(busy),    0);
    checkOutput("midrst_wr_addr", 32'(wr_addr), 0);
    checkOutput("midrst_wr_data", 32'(wr_data), 0);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    pushExpect(1, 7'h04, 8'h80);
    applyStimulus(32'h8480, 16, 8);
    checkOutput("midrst_addr_after", 32'(wr_addr), 32'h04);
    checkOutput("midrst_data_after", 32'(wr_data), 32'h80);

    // busy start and end, plus strobe latency counted from the first sampling edge.
    pushExpect(1, 7'h02, 8'h5A);
    @(posedge clk);
    #1 ncs_in = 1'b0;
    for (int k = 1; k <= SYNC_STAGES + 1; k++) begin
      @(posedge clk);
      #2;
      if (k == SYNC_STAGES) checkOutput("busy_before_start", 32'(busy), 0);
      if (k == SYNC_STAGES + 1) checkOutput("busy_after_start", 32'(busy), 1);
    end
    repeat (2) @(posedge clk);
    #1;
    shiftBits(32'h825A, 16);
    @(posedge clk);
    #1 ncs_in = 1'b1;
    edge_n = 0;
    while (!wr_valid && edge_n < 12) begin
      @(posedge clk);
      edge_n++;
      #2;
      if (edge_n == SYNC_STAGES) checkOutput("busy_before_check", 32'(busy), 1);
      if (edge_n == SYNC_STAGES + 1) checkOutput("busy_in_check", 32'(busy), 0);
    end
    checkOutput("strobe_latency", edge_n, SYNC_STAGES + 2);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("latency_addr", 32'(wr_addr), 32'h02);

    repeat (10) @(posedge clk);
    #1;
    checkOutput("pending_expectations", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
